ldmstm_sequencer: RTL and testbench

//  Stage-1 front-end controller between decode and Issue. It expands each LDM/STM into one micro-op per listed register.
//  - Holds the block-transfer instruction and back-pressures fetch/decode until every beat has gone downstream.
//  - Non-block instructions pass through as a single beat with 1-cycle latency.
//  - Condition codes are not evaluated here; Issue does that.

---
 rtl/ldmstm_sequencer_if.sv | 29 ++
 rtl/ldmstm_sequencer.sv | 147 ++++++++++++++
 tb/tb_ldmstm_sequencer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ldmstm_sequencer_if.sv
// Decode-to-Issue bus around the LDM/STM sequencer. The master side is the
// sequencer. The slave side is its environment: decode upstream, Issue downstream.
interface ldmstm_sequencer_if;
    logic        stall_1a;
    logic        flush_1a;
    logic        bubble_0a;
    logic [31:0] insn_0a;
    logic [31:0] pc_0a;
    logic        stall_0a;
    logic        bubble_1a;
    logic [31:0] insn_1a;
    logic [31:0] pc_1a;
    logic [3:0]  uop_reg_1a;
    logic [4:0]  uop_idx_1a;
    logic        uop_first_1a;
    logic        uop_last_1a;

    modport master (
        input  stall_1a, flush_1a, bubble_0a, insn_0a, pc_0a,
        output stall_0a, bubble_1a, insn_1a, pc_1a,
               uop_reg_1a, uop_idx_1a, uop_first_1a, uop_last_1a
    );

    modport slave (
        output stall_1a, flush_1a, bubble_0a, insn_0a, pc_0a,
        input  stall_0a, bubble_1a, insn_1a, pc_1a,
               uop_reg_1a, uop_idx_1a, uop_first_1a, uop_last_1a
    );
endinterface

// File: rtl/ldmstm_sequencer.sv
// LDM/STM sequencer. It expands a block-transfer instruction into one beat per
// listed register and holds decode off until the last beat has gone out.
// Every other instruction passes through as a single beat one cycle later.
module ldmstm_sequencer #(
    parameter bit REG_ORDER_ASC = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_b,
    ldmstm_sequencer_if.master   bus
);

    typedef enum logic {IDLE, SEQ} state_t;

    state_t      state, state_n;
    logic [15:0] rem, rem_n;
    logic        bubble_q, bubble_n;
    logic [31:0] insn_q, insn_n;
    logic [31:0] pc_q, pc_n;
    logic [3:0]  reg_q, reg_n;
    logic [4:0]  idx_q, idx_n;
    logic        first_q, first_n;
    logic        last_q, last_n;

    logic        is_blk;
    logic [15:0] list;
    logic        list_multi;
    logic [3:0]  pick_list;
    logic [3:0]  pick_rem;
    logic [15:0] rem_after;

    // Register to transfer next: the lowest set bit in ascending order, or the
    // highest set bit otherwise. An empty mask gives r0.
    function automatic logic [3:0] pick(input logic [15:0] m);
        logic [3:0] r;
        r = 4'd0;
        if (REG_ORDER_ASC) begin
            for (int i = 15; i >= 0; i--)
                if (m[i]) r = 4'(i);
        end else begin
            for (int i = 0; i < 16; i++)
                if (m[i]) r = 4'(i);
        end
        return r;
    endfunction

    function automatic logic [15:0] onehot(input logic [3:0] n);
        return 16'd1 << n;
    endfunction

    assign is_blk     = !bus.bubble_0a && (bus.insn_0a[27:25] == 3'b100);
    assign list       = bus.insn_0a[15:0];
    assign list_multi = (list & (list - 16'd1)) != 16'd0;
    assign pick_list  = pick(list);
    assign pick_rem   = pick(rem);
    assign rem_after  = rem & ~onehot(pick_rem);

    // Hold decode while more beats are owed. A flush releases decode
    // immediately because it abandons the sequence.
    assign bus.stall_0a = bus.stall_1a | ((state == SEQ) & !bus.flush_1a);

    assign bus.bubble_1a    = bubble_q;
    assign bus.insn_1a      = insn_q;
    assign bus.pc_1a        = pc_q;
    assign bus.uop_reg_1a   = reg_q;
    assign bus.uop_idx_1a   = idx_q;
    assign bus.uop_first_1a = first_q;
    assign bus.uop_last_1a  = last_q;

    // Next-state and next-beat selection. Flush wins over stall. Stall freezes
    // everything. In SEQ the held instruction is already on insn_q and pc_q.
    always_comb begin
        state_n  = state;
        rem_n    = rem;
        bubble_n = bubble_q;
        insn_n   = insn_q;
        pc_n     = pc_q;
        reg_n    = reg_q;
        idx_n    = idx_q;
        first_n  = first_q;
        last_n   = last_q;
        if (bus.flush_1a) begin
            state_n  = IDLE;
            rem_n    = 16'd0;
            bubble_n = 1'b1;
        end else if (!bus.stall_1a) begin
            case (state)
                IDLE: begin
                    if (bus.bubble_0a) begin
                        bubble_n = 1'b1;
                    end else begin
                        bubble_n = 1'b0;
                        insn_n   = bus.insn_0a;
                        pc_n     = bus.pc_0a;
                        idx_n    = 5'd0;
                        first_n  = 1'b1;
                        last_n   = 1'b1;
                        reg_n    = 4'd0;
                        if (is_blk) begin
                            reg_n = pick_list;
                            if (list_multi) begin
                                last_n  = 1'b0;
                                rem_n   = list & ~onehot(pick_list);
                                state_n = SEQ;
                            end
                        end
                    end
                end
                SEQ: begin
                    bubble_n = 1'b0;
                    reg_n    = pick_rem;
                    idx_n    = idx_q + 5'd1;
                    first_n  = 1'b0;
                    rem_n    = rem_after;
                    last_n   = (rem_after == 16'd0);
                    if (rem_after == 16'd0) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // State and output registers. Reset drops any held instruction at once.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state    <= IDLE;
            rem      <= 16'd0;
            bubble_q <= 1'b1;
            insn_q   <= 32'd0;
            pc_q     <= 32'd0;
            reg_q    <= 4'd0;
            idx_q    <= 5'd0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state    <= state_n;
            rem      <= rem_n;
            bubble_q <= bubble_n;
            insn_q   <= insn_n;
            pc_q     <= pc_n;
            reg_q    <= reg_n;
            idx_q    <= idx_n;
            first_q  <= first_n;
            last_q   <= last_n;
        end
    end

endmodule

// File: tb/tb_ldmstm_sequencer.sv
// Bench for ldmstm_sequencer. Two instances share one stimulus stream: one
// issues registers in ascending order and one in descending order. A reference
// model turns each accepted instruction into its expected list of beats.
module tb_ldmstm_sequencer;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        stall_1a, flush_1a, bubble_0a;
    logic [31:0] insn_0a, pc_0a;
    logic [31:0] pc_ctr;

    always #5 clk = ~clk;

    ldmstm_sequencer_if u_if_a ();
    ldmstm_sequencer_if u_if_d ();

    assign u_if_a.stall_1a  = stall_1a;
    assign u_if_a.flush_1a  = flush_1a;
    assign u_if_a.bubble_0a = bubble_0a;
    assign u_if_a.insn_0a   = insn_0a;
    assign u_if_a.pc_0a     = pc_0a;
    assign u_if_d.stall_1a  = stall_1a;
    assign u_if_d.flush_1a  = flush_1a;
    assign u_if_d.bubble_0a = bubble_0a;
    assign u_if_d.insn_0a   = insn_0a;
    assign u_if_d.pc_0a     = pc_0a;

    ldmstm_sequencer #(.REG_ORDER_ASC(1'b1)) u_dut_a (.clk(clk), .rst_b(rst_b), .bus(u_if_a));
    ldmstm_sequencer #(.REG_ORDER_ASC(1'b0)) u_dut_d (.clk(clk), .rst_b(rst_b), .bus(u_if_d));

    logic [75:0] out_a, out_d;
    assign out_a = {u_if_a.bubble_1a, u_if_a.insn_1a, u_if_a.pc_1a, u_if_a.uop_reg_1a,
                    u_if_a.uop_idx_1a, u_if_a.uop_first_1a, u_if_a.uop_last_1a};
    assign out_d = {u_if_d.bubble_1a, u_if_d.insn_1a, u_if_d.pc_1a, u_if_d.uop_reg_1a,
                    u_if_d.uop_idx_1a, u_if_d.uop_first_1a, u_if_d.uop_last_1a};

    localparam logic [75:0] RESET_OUT = {1'b1, 75'd0};

    typedef struct {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [3:0]  reg_a;
        logic [3:0]  reg_d;
        logic [4:0]  idx;
        logic        first;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one beat per set bit of the register list, taken in
    // register-number order. Anything other than a block transfer, and a block
    // transfer with an empty list, is a single beat for r0.
    task automatic push_beats(input logic [31:0] ins, input logic [31:0] pc);
        int    bits[$];
        beat_t b;
        if (ins[27:25] == 3'b100)
            for (int i = 0; i < 16; i++)
                if (ins[i]) bits.push_back(i);
        b.insn = ins;
        b.pc   = pc;
        if (bits.size() == 0) begin
            b.reg_a = 4'd0; b.reg_d = 4'd0; b.idx = 5'd0; b.first = 1'b1; b.last = 1'b1;
            exp_q.push_back(b);
        end else begin
            for (int k = 0; k < bits.size(); k++) begin
                b.reg_a = 4'(bits[k]);
                b.reg_d = 4'(bits[bits.size() - 1 - k]);
                b.idx   = 5'(k);
                b.first = (k == 0);
                b.last  = (k == bits.size() - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    // One input cycle. Inputs are driven after the falling edge, then checked
    // against the expected decode stall. The model accepts an instruction only
    // when no beats of an earlier one are outstanding.
    task automatic cyc(input logic bub, input logic [31:0] ins, input logic st, input logic fl);
        logic exp_st;
        @(negedge clk);
        bubble_0a = bub;
        insn_0a   = ins;
        pc_0a     = pc_ctr;
        stall_1a  = st;
        flush_1a  = fl;
        #1;
        exp_st = st | ((exp_q.size() != 0) && !fl);
        chk("stall_0a_asc", 80'(u_if_a.stall_0a), 80'(exp_st));
        chk("stall_0a_desc", 80'(u_if_d.stall_0a), 80'(exp_st));
        if (fl) exp_q.delete();
        else if (!st && !bub && exp_q.size() == 0) push_beats(ins, pc_ctr);
        pc_ctr = pc_ctr + 32'd4;
    endtask

    // Pull reset low between edges while a sequence is in progress. The
    // outputs must clear at once, without waiting for a clock edge.
    task automatic reset_mid();
        @(negedge clk);
        bubble_0a = 1'b1;
        stall_1a  = 1'b0;
        flush_1a  = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        chk("async_rst_out_asc", 80'(out_a), 80'(RESET_OUT));
        chk("async_rst_out_desc", 80'(out_d), 80'(RESET_OUT));
        chk("async_rst_stall_0a", 80'(u_if_a.stall_0a), 80'(stall_1a));
        exp_q.delete();
        @(negedge clk);
        #2 rst_b = 1'b1;
    endtask

    // Monitor: after each rising edge, decide what the edge must have produced
    // and compare the outputs with the head of the expected-beat queue.
    initial begin
        logic        s_st, s_fl, s_rst;
        logic [75:0] snap_a, snap_d;
        beat_t       b;
        snap_a = RESET_OUT;
        snap_d = RESET_OUT;
        forever begin
            @(posedge clk);
            s_st  = stall_1a;
            s_fl  = flush_1a;
            s_rst = rst_b;
            #1;
            if (!s_rst) begin
                chk("reset_out_asc", 80'(out_a), 80'(RESET_OUT));
                chk("reset_out_desc", 80'(out_d), 80'(RESET_OUT));
            end else if (s_fl) begin
                chk("flush_bubble_asc", 80'(u_if_a.bubble_1a), 80'd1);
                chk("flush_bubble_desc", 80'(u_if_d.bubble_1a), 80'd1);
            end else if (s_st) begin
                chk("stall_hold_asc", 80'(out_a), 80'(snap_a));
                chk("stall_hold_desc", 80'(out_d), 80'(snap_d));
            end else if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("beat_bubble_asc", 80'(u_if_a.bubble_1a), 80'd0);
                chk("beat_insn", 80'(u_if_a.insn_1a), 80'(b.insn));
                chk("beat_pc", 80'(u_if_a.pc_1a), 80'(b.pc));
                chk("beat_reg_asc", 80'(u_if_a.uop_reg_1a), 80'(b.reg_a));
                chk("beat_idx_asc", 80'(u_if_a.uop_idx_1a), 80'(b.idx));
                chk("beat_first_asc", 80'(u_if_a.uop_first_1a), 80'(b.first));
                chk("beat_last_asc", 80'(u_if_a.uop_last_1a), 80'(b.last));
                chk("beat_bubble_desc", 80'(u_if_d.bubble_1a), 80'd0);
                chk("beat_insn_desc", 80'(u_if_d.insn_1a), 80'(b.insn));
                chk("beat_reg_desc", 80'(u_if_d.uop_reg_1a), 80'(b.reg_d));
                chk("beat_idx_desc", 80'(u_if_d.uop_idx_1a), 80'(b.idx));
                chk("beat_first_desc", 80'(u_if_d.uop_first_1a), 80'(b.first));
                chk("beat_last_desc", 80'(u_if_d.uop_last_1a), 80'(b.last));
            end else begin
                chk("idle_bubble_asc", 80'(u_if_a.bubble_1a), 80'd1);
                chk("idle_bubble_desc", 80'(u_if_d.bubble_1a), 80'd1);
            end
            snap_a = out_a;
            snap_d = out_d;
        end
    end

    function automatic logic [31:0] rand_insn();
        logic [31:0] r;
        r = $urandom;
        if ($urandom_range(0, 1) == 1) begin
            r[27:25] = 3'b100;
            case ($urandom_range(0, 3))
                0:       r[15:0] = 16'd0;
                1:       r[15:0] = 16'd1 << $urandom_range(0, 15);
                2:       r[15:0] = 16'($urandom);
                default: r[15:0] = 16'($urandom) & 16'($urandom);
            endcase
        end else if (r[27:25] == 3'b100) begin
            r[25] = 1'b1;
        end
        return r;
    endfunction

    // Stimulus
    initial begin
        rst_b     = 1'b0;
        stall_1a  = 1'b0;
        flush_1a  = 1'b0;
        bubble_0a = 1'b1;
        insn_0a   = 32'd0;
        pc_0a     = 32'd0;
        pc_ctr    = 32'h0000_1000;
        repeat (2) @(negedge clk);
        #2 rst_b = 1'b1;

        // LDMIA r0,{r1,r4,r15} with no stalls
        cyc(0, 32'hE890_8012, 0, 0);
        repeat (3) cyc(1, 32'd0, 0, 0);
        // plain ALU instruction
        cyc(0, 32'hE081_2003, 0, 0);
        repeat (2) cyc(1, 32'd0, 0, 0);
        // stall for three cycles after beat 1
        cyc(0, 32'hE890_8012, 0, 0);
        cyc(1, 32'd0, 0, 0);
        repeat (3) cyc(1, 32'd0, 1, 0);
        repeat (3) cyc(1, 32'd0, 0, 0);
        // STMDB sp!,{r0-r3} flushed during beat 1, then a fresh instruction
        cyc(0, 32'hE92D_000F, 0, 0);
        cyc(1, 32'd0, 0, 0);
        cyc(0, 32'hE081_2003, 0, 1);
        cyc(0, 32'hE081_2003, 0, 0);
        cyc(1, 32'd0, 0, 0);
        // empty register list
        cyc(0, 32'hE890_0000, 0, 0);
        cyc(1, 32'd0, 0, 0);
        // async reset part-way through a sequence, then restart from idx 0
        cyc(0, 32'hE890_8012, 0, 0);
        reset_mid();
        cyc(0, 32'hE890_8012, 0, 0);
        repeat (3) cyc(1, 32'd0, 0, 0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if (n == 700 || n == 1200) begin
                if (exp_q.size() == 0) cyc(0, 32'hE890_FFFF, 0, 0);
                reset_mid();
            end
            cyc(($urandom_range(0, 4) == 0), rand_insn(),
                ($urandom_range(0, 4) == 0), ($urandom_range(0, 29) == 0));
        end
        repeat (20) cyc(1, 32'd0, 0, 0);
        chk("queue_drained", 80'(exp_q.size()), 80'd0);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
